vip_crop_window: RTL and testbench
==================================

// Module: vip_crop_window
// PURPOSE
//  Next-gen VIP crop. Cuts a rectangular window out of a raster stream carrying PPC pixels per clock.
//  Window registers are shadowed per frame, so software can update them at any time without tearing.
//  Also measures the incoming frame size and flags windows that do not fit. Sits after sensor input, before the ISP core.
// PARAMETERS
//  BITS   12  bits per pixel
//  PPC    1   pixels per clock, one of 1, 2, 4; LG = log2(PPC)
// PORTS
//  pclk         in   1         clock; all logic rising-edge
//  rst          in   1         synchronous, active-high reset
//  crop_en      in   1         1=crop, 0=pass full frame; shadowed
//  crop_x       in   16        window left, pixels; low LG bits ignored; shadowed
//  crop_y       in   16        window top, lines; shadowed
//  crop_w       in   16        window width, pixels; low LG bits ignored; shadowed
//  crop_h       in   16        window height, lines; shadowed
//  in_href      in   1         input line valid
//  in_vsync     in   1         input vsync; high = vertical blanking
//  in_data      in   BITS*PPC  PPC pixels, pixel 0 in LSBs
//  out_href     out  1         output line valid
//  out_vsync    out  1         in_vsync delayed 1 clk
//  out_data     out  BITS*PPC  cropped pixels; 0 when out_href=0
//  frame_width  out  16        pixels/line of line 0 of last complete frame
//  frame_height out  16        line count of last complete frame
//  crop_err     out  1         shadow window exceeds last measured size
//  frame_done   out  1         1-clk pulse on rising in_vsync after an ACTIVE frame
// BEHAVIOUR
//  Reset: all outputs 0; counters 0; shadows 0; FSM=WAIT.
//  frame_start = falling edge of in_vsync (registered prev_vsync & ~in_vsync).
//  FSM WAIT: outputs held idle; on frame_start -> ACTIVE.
//  FSM ACTIVE: on rising in_vsync -> DONE. Reset mid-frame -> WAIT; rest of that frame suppressed.
//  FSM DONE: one cycle; pulse frame_done; update frame_width/height; -> WAIT.
//  On frame_start, latch shadows from crop_* and crop_en. cx = crop_x>>LG, cw = crop_w>>LG, in clock beats.
//  crop_err at frame_start = en & width/height nonzero & (x+w > width | y+h > height), sums 17 bits.
//  crop_err then holds until the next frame_start.
//  beat_cnt: 0 on the first beat of each href-high run; +1 per href beat; saturates at 0xFFFF.
//  line_cnt: 0 at frame_start; +1 on each href falling edge; saturates at 0xFFFF.
//  Width measure: beat count of line 0 times PPC, captured at its href fall. Height = line_cnt at DONE.
//  Window test, all compares 17-bit so there is no wrap-around:
//   beat in [cx, cx+cw) and line in [y, y+h) and in_href and state==ACTIVE.
//  crop_en=0: window = every beat with href high in ACTIVE.
//  Latency: exactly 1 clk. out_href, out_data and out_vsync are all registered together.
//  w=0 or h=0 -> no output href for the whole frame; vsync still passes through.
//  Window beyond the frame: output is clipped to real pixels only; crop_err=1.
//  Live crop_* changes during ACTIVE have no effect until the next frame_start.
// TESTING
//  PPC=1, 8x6 frame, x=2 y=1 w=4 h=3 -> 3 lines x 4 px; data = in px 2..5, 1 clk late.
//  PPC=2, 16-px lines, x=5 w=7 -> x=4, w=6 px, i.e. 3 beats at beats 2..4.
//  Change crop_x mid-frame -> current frame unchanged; next frame uses new x.
//  Frame1 8x6, frame2 window x=6 w=4 -> crop_err=1 in frame2; output 2 px/line.
//  Frame1 8x6 -> frame_done pulses 1 clk on vsync rise; frame_width=8, frame_height=6.
//  Assert rst mid-line -> outputs 0 next clk; no output until the next vsync fall.

Source files
------------

// File: rtl/vip_crop_window.sv
// Raster-stream crop with per-frame shadowed window registers, incoming
// frame-size measurement and a window-fit error flag. PPC pixels per beat.
module vip_crop_window #(
    parameter int BITS = 12,
    parameter int PPC  = 1
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                crop_en,
    input  logic [15:0]         crop_x,
    input  logic [15:0]         crop_y,
    input  logic [15:0]         crop_w,
    input  logic [15:0]         crop_h,
    input  logic                in_href,
    input  logic                in_vsync,
    input  logic [BITS*PPC-1:0] in_data,
    output logic                out_href,
    output logic                out_vsync,
    output logic [BITS*PPC-1:0] out_data,
    output logic [15:0]         frame_width,
    output logic [15:0]         frame_height,
    output logic                crop_err,
    output logic                frame_done
);

    localparam int          LG       = (PPC == 4) ? 2 : ((PPC == 2) ? 1 : 0);
    localparam logic [15:0] PIX_MASK = ~(16'(PPC) - 16'd1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  prev_vsync_r;
    logic                  prev_href_r;
    logic                  frame_start_s;
    logic                  vsync_rise_s;
    logic                  href_fall_s;
    logic                  sh_en_r;
    logic [15:0]           sh_cx_r;
    logic [15:0]           sh_cw_r;
    logic [15:0]           sh_y_r;
    logic [15:0]           sh_h_r;
    logic [15:0]           run_cnt_r;
    logic [15:0]           line_cnt_r;
    logic [15:0]           meas_w_r;
    logic [15:0]           beat_s;
    logic [16:0]           x_end_s;
    logic [16:0]           y_end_s;
    logic                  err_s;
    logic                  beat_ok_s;
    logic                  line_ok_s;
    logic                  win_s;
    logic                  out_href_r;
    logic                  out_vsync_r;
    logic [BITS*PPC-1:0]   out_data_r;
    logic [15:0]           frame_width_r;
    logic [15:0]           frame_height_r;
    logic                  crop_err_r;
    logic                  frame_done_r;

    // Sync edge detection and current beat index within the href run
    always_comb begin
        frame_start_s = prev_vsync_r & ~in_vsync;
        vsync_rise_s  = ~prev_vsync_r & in_vsync;
        href_fall_s   = prev_href_r & ~in_href;
        if (prev_href_r) begin
            beat_s = run_cnt_r;
        end else begin
            beat_s = 16'd0;
        end
    end

    // Fit check of the incoming window against the last measured frame (17-bit sums)
    always_comb begin
        x_end_s = {1'b0, crop_x & PIX_MASK} + {1'b0, crop_w & PIX_MASK};
        y_end_s = {1'b0, crop_y} + {1'b0, crop_h};
        if (crop_en && (frame_width_r != 16'd0) && (frame_height_r != 16'd0)) begin
            err_s = (x_end_s > {1'b0, frame_width_r}) || (y_end_s > {1'b0, frame_height_r});
        end else begin
            err_s = 1'b0;
        end
    end

    // Window membership of the current beat, compared in 17 bits so ends never wrap
    always_comb begin
        beat_ok_s = ({1'b0, beat_s} >= {1'b0, sh_cx_r}) &&
                    ({1'b0, beat_s} < ({1'b0, sh_cx_r} + {1'b0, sh_cw_r}));
        line_ok_s = ({1'b0, line_cnt_r} >= {1'b0, sh_y_r}) &&
                    ({1'b0, line_cnt_r} < ({1'b0, sh_y_r} + {1'b0, sh_h_r}));
        if (in_href && (state_r == ST_ACTIVE)) begin
            win_s = ~sh_en_r | (beat_ok_s & line_ok_s);
        end else begin
            win_s = 1'b0;
        end
    end

    // Frame FSM next-state
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (frame_start_s) begin
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_DONE: state_s = ST_WAIT;
            default: state_s = ST_WAIT;
        endcase
    end

    // FSM state and previous-sample registers for edge detection
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r      <= ST_WAIT;
            prev_vsync_r <= 1'b0;
            prev_href_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            prev_vsync_r <= in_vsync;
            prev_href_r  <= in_href;
        end
    end

    // Shadow window and fit flag, both taken once per frame at vsync fall
    always_ff @(posedge pclk) begin
        if (rst) begin
            sh_en_r    <= 1'b0;
            sh_cx_r    <= 16'd0;
            sh_cw_r    <= 16'd0;
            sh_y_r     <= 16'd0;
            sh_h_r     <= 16'd0;
            crop_err_r <= 1'b0;
        end else if (frame_start_s) begin
            sh_en_r    <= crop_en;
            sh_cx_r    <= crop_x >> LG;
            sh_cw_r    <= crop_w >> LG;
            sh_y_r     <= crop_y;
            sh_h_r     <= crop_h;
            crop_err_r <= err_s;
        end else begin
            crop_err_r <= crop_err_r;
        end
    end

    // Beat/line counters and line-0 width capture
    always_ff @(posedge pclk) begin
        if (rst) begin
            run_cnt_r  <= 16'd0;
            line_cnt_r <= 16'd0;
            meas_w_r   <= 16'd0;
        end else begin
            if (in_href) begin
                run_cnt_r <= (beat_s == 16'hFFFF) ? 16'hFFFF : (beat_s + 16'd1);
            end
            if (frame_start_s) begin
                line_cnt_r <= 16'd0;
                meas_w_r   <= 16'd0;
            end else if ((state_r == ST_ACTIVE) && href_fall_s) begin
                if (line_cnt_r != 16'hFFFF) begin
                    line_cnt_r <= line_cnt_r + 16'd1;
                end
                if (line_cnt_r == 16'd0) begin
                    meas_w_r <= run_cnt_r << LG;
                end
            end
        end
    end

    // Registered video outputs and end-of-frame reporting
    always_ff @(posedge pclk) begin
        if (rst) begin
            out_href_r     <= 1'b0;
            out_vsync_r    <= 1'b0;
            out_data_r     <= {(BITS*PPC){1'b0}};
            frame_done_r   <= 1'b0;
            frame_width_r  <= 16'd0;
            frame_height_r <= 16'd0;
        end else begin
            out_href_r   <= win_s;
            out_vsync_r  <= in_vsync;
            out_data_r   <= win_s ? in_data : {(BITS*PPC){1'b0}};
            frame_done_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                frame_width_r  <= meas_w_r;
                frame_height_r <= line_cnt_r;
            end
        end
    end

    assign out_href     = out_href_r;
    assign out_vsync    = out_vsync_r;
    assign out_data     = out_data_r;
    assign frame_width  = frame_width_r;
    assign frame_height = frame_height_r;
    assign crop_err     = crop_err_r;
    assign frame_done   = frame_done_r;

endmodule

// File: tb/tb_vip_crop_window.sv
// Bench for vip_crop_window: PPC=1 and PPC=2 instances share one raster stream,
// checked every cycle against a frame-coordinate reference model.
module tb_vip_crop_window;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst, crop_en, in_href, in_vsync;
    logic [15:0] crop_x, crop_y, crop_w, crop_h;
    logic [11:0] in_data1;
    logic [23:0] in_data2;
    logic        out_href1, out_vsync1, crop_err1, frame_done1;
    logic        out_href2, out_vsync2, crop_err2, frame_done2;
    logic [11:0] out_data1;
    logic [23:0] out_data2;
    logic [15:0] frame_width1, frame_height1, frame_width2, frame_height2;

    vip_crop_window #(.BITS(12), .PPC(1)) dut1 (
        .pclk(pclk), .rst(rst), .crop_en(crop_en), .crop_x(crop_x), .crop_y(crop_y),
        .crop_w(crop_w), .crop_h(crop_h), .in_href(in_href), .in_vsync(in_vsync),
        .in_data(in_data1), .out_href(out_href1), .out_vsync(out_vsync1),
        .out_data(out_data1), .frame_width(frame_width1), .frame_height(frame_height1),
        .crop_err(crop_err1), .frame_done(frame_done1)
    );

    vip_crop_window #(.BITS(12), .PPC(2)) dut2 (
        .pclk(pclk), .rst(rst), .crop_en(crop_en), .crop_x(crop_x), .crop_y(crop_y),
        .crop_w(crop_w), .crop_h(crop_h), .in_href(in_href), .in_vsync(in_vsync),
        .in_data(in_data2), .out_href(out_href2), .out_vsync(out_vsync2),
        .out_data(out_data2), .frame_width(frame_width2), .frame_height(frame_height2),
        .crop_err(crop_err2), .frame_done(frame_done2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_oh1, n_oh2, n_fd1;

    // reference model state: shadow window, frame-active flag, measured sizes
    bit m_prev_vs, m_active, m_pend, m_err1, m_err2, sh_en;
    int sh_x, sh_y, sh_w, sh_h;
    int m_fw1, m_fw2, m_fh, p_beats, p_lines, f_beats, f_lines;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input int l, input int b, input int lg);
        int cx, cw;
        cx = sh_x >> lg;
        cw = sh_w >> lg;
        if (!sh_en) return 1'b1;
        return (b >= cx) && (b < cx + cw) && (l >= sh_y) && (l < sh_y + sh_h);
    endfunction

    function automatic bit calc_err(input int fw, input int lg);
        int xe;
        xe = ((sh_x >> lg) << lg) + ((sh_w >> lg) << lg);
        return sh_en && (fw != 0) && (m_fh != 0) && ((xe > fw) || (sh_y + sh_h > m_fh));
    endfunction

    task automatic rand_crop();
        crop_en = ($urandom_range(0, 3) != 0);
        crop_x  = 16'($urandom_range(0, 12));
        crop_y  = 16'($urandom_range(0, 8));
        crop_w  = 16'($urandom_range(0, 12));
        crop_h  = 16'($urandom_range(0, 8));
        if ($urandom_range(0, 7) == 0) crop_w = 16'hFFFF - 16'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) crop_x = 16'hFFFE;
    endtask

    // one clock: drive inputs, advance model, check all outputs 1 ns after the edge
    task automatic step(input bit r, input bit href, input bit vs, input int l, input int b);
        bit fs, rise, w1, w2, e_done;
        logic [11:0] e_d1;
        logic [23:0] e_d2;
        rst = r; in_href = href; in_vsync = vs;
        in_data1 = 12'($urandom);
        in_data2 = 24'($urandom);
        e_done = 1'b0; w1 = 1'b0; w2 = 1'b0;
        if (r) begin
            m_prev_vs = 1'b0; m_active = 1'b0; m_pend = 1'b0;
            m_fw1 = 0; m_fw2 = 0; m_fh = 0; m_err1 = 1'b0; m_err2 = 1'b0;
        end else begin
            e_done = m_pend;
            if (m_pend) begin
                m_fw1 = p_beats; m_fw2 = 2 * p_beats; m_fh = p_lines; m_pend = 1'b0;
            end
            fs   = m_prev_vs && !vs;
            rise = !m_prev_vs && vs;
            w1 = m_active && href && in_win(l, b, 0);
            w2 = m_active && href && in_win(l, b, 1);
            if (fs) begin
                sh_en = crop_en; sh_x = crop_x; sh_y = crop_y; sh_w = crop_w; sh_h = crop_h;
                m_err1 = calc_err(m_fw1, 0);
                m_err2 = calc_err(m_fw2, 1);
                m_active = 1'b1;
            end
            if (rise && m_active) begin
                m_active = 1'b0; m_pend = 1'b1; p_beats = f_beats; p_lines = f_lines;
            end
            m_prev_vs = vs;
        end
        e_d1 = w1 ? in_data1 : 12'd0;
        e_d2 = w2 ? in_data2 : 24'd0;
        @(posedge pclk);
        #1;
        if (out_href1)   n_oh1++;
        if (out_href2)   n_oh2++;
        if (frame_done1) n_fd1++;
        chk_val("href1",  32'(out_href1),     32'(w1));
        chk_val("data1",  32'(out_data1),     32'(e_d1));
        chk_val("vsync1", 32'(out_vsync1),    32'(vs && !r));
        chk_val("done1",  32'(frame_done1),   32'(e_done));
        chk_val("fw1",    32'(frame_width1),  32'(m_fw1));
        chk_val("fh1",    32'(frame_height1), 32'(m_fh));
        chk_val("err1",   32'(crop_err1),     32'(m_err1));
        chk_val("href2",  32'(out_href2),     32'(w2));
        chk_val("data2",  32'(out_data2),     32'(e_d2));
        chk_val("vsync2", 32'(out_vsync2),    32'(vs && !r));
        chk_val("done2",  32'(frame_done2),   32'(e_done));
        chk_val("fw2",    32'(frame_width2),  32'(m_fw2));
        chk_val("fh2",    32'(frame_height2), 32'(m_fh));
        chk_val("err2",   32'(crop_err2),     32'(m_err2));
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 0, 0);
    endtask

    // vertical blanking, then `lines` lines; line 0 has `beats` beats
    task automatic frame(input int lines, input int beats, input int vb,
                         input int chg_line, input int rst_line, input bit vary);
        int len;
        blank(vb);
        f_beats = beats;
        f_lines = lines;
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        for (int l = 0; l < lines; l++) begin
            len = (vary && l != 0) ? $urandom_range(1, beats + 2) : beats;
            if (l == chg_line) rand_crop();
            for (int b = 0; b < len; b++)
                step((l == rst_line) && (b == len / 2), 1'b1, 1'b0, l, b);
            step(1'b0, 1'b0, 1'b0, 0, 0);
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        int lines;
        rst = 1'b1; crop_en = 1'b0; crop_x = 16'd0; crop_y = 16'd0; crop_w = 16'd0; crop_h = 16'd0;
        in_href = 1'b0; in_vsync = 1'b1; in_data1 = 12'd0; in_data2 = 24'd0;
        m_prev_vs = 1'b0; m_active = 1'b0; m_pend = 1'b0; m_err1 = 1'b0; m_err2 = 1'b0;
        sh_en = 1'b0; sh_x = 0; sh_y = 0; sh_w = 0; sh_h = 0;
        m_fw1 = 0; m_fw2 = 0; m_fh = 0; p_beats = 0; p_lines = 0; f_beats = 0; f_lines = 0;
        n_oh1 = 0; n_oh2 = 0; n_fd1 = 0;

        step(1'b1, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b0, 1'b1, 0, 0);
        chk_val("rst_fw1", 32'(frame_width1), 32'd0);
        chk_val("rst_err1", 32'(crop_err1), 32'd0);
        blank(2);

        // 8x6 frame, x=2 y=1 w=4 h=3
        crop_en = 1'b1; crop_x = 16'd2; crop_y = 16'd1; crop_w = 16'd4; crop_h = 16'd3;
        n_oh1 = 0; n_oh2 = 0;
        frame(6, 8, 3, -1, -1, 1'b0);
        chk_val("A_px1", 32'(n_oh1), 32'd12);
        chk_val("A_px2", 32'(n_oh2), 32'd6);
        blank(3);
        chk_val("A_fw1", 32'(frame_width1), 32'd8);
        chk_val("A_fh1", 32'(frame_height1), 32'd6);
        chk_val("A_fw2", 32'(frame_width2), 32'd16);
        chk_val("A_fd", 32'(n_fd1), 32'd1);

        // x=5 w=7: PPC=2 sees beats 2..4; PPC=1 clipped to px 5..7 with error
        crop_x = 16'd5; crop_w = 16'd7;
        n_oh1 = 0; n_oh2 = 0;
        frame(6, 8, 3, -1, -1, 1'b0);
        chk_val("B_px1", 32'(n_oh1), 32'd9);
        chk_val("B_px2", 32'(n_oh2), 32'd9);
        chk_val("B_err1", 32'(crop_err1), 32'd1);
        chk_val("B_err2", 32'(crop_err2), 32'd0);

        // x=6 w=4 beyond an 8-px frame; live crop change on line 2 must not matter
        crop_x = 16'd6; crop_y = 16'd0; crop_w = 16'd4; crop_h = 16'd6;
        n_oh1 = 0; n_oh2 = 0;
        frame(6, 8, 3, 2, -1, 1'b0);
        chk_val("C_px1", 32'(n_oh1), 32'd12);
        chk_val("C_px2", 32'(n_oh2), 32'd12);
        chk_val("C_err1", 32'(crop_err1), 32'd1);

        // pass-through frame with reset in the middle of line 1
        crop_en = 1'b0;
        n_oh1 = 0; n_oh2 = 0;
        frame(4, 8, 3, -1, 1, 1'b0);
        chk_val("E_px1", 32'(n_oh1), 32'd12);
        chk_val("E_px2", 32'(n_oh2), 32'd12);
        blank(4);
        chk_val("E_fw1", 32'(frame_width1), 32'd0);
        chk_val("E_fh1", 32'(frame_height1), 32'd0);

        for (int k = 0; k < 24; k++) begin
            rand_crop();
            lines = $urandom_range(1, 7);
            frame(lines, $urandom_range(1, 10), $urandom_range(2, 4), $urandom_range(0, lines),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, lines - 1) : -1, 1'b1);
        end
        blank(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
